counter_checker: RTL

- Receive-side monitor for the free-running counter's `cout` stream.
- Samples the counter value on qualified cycles and checks that each sample equals the previous sample plus one, modulo 2^WIDTH.
- Acquires lock, then reports sequence violations through an error pulse, a sticky flag and a saturating error count.
- Sits beside the counter in the lab benches and in the integrated design as a self-checking consumer.

---
 rtl/counter_chk_pkg.sv | 21 ++
 rtl/counter_checker_sat_cnt.sv | 37 +++
 rtl/counter_checker.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/counter_chk_pkg.sv
// ============================================================================
// counter_chk_pkg : shared state encoding and default sizes for counter_checker
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_chk_pkg;

    typedef enum logic [1:0] {
        SEEK = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam int c_def_width    = 8;
    localparam int c_def_lock_cnt = 4;
    localparam int c_def_err_w    = 16;

endpackage

`default_nettype wire

// File: rtl/counter_checker_sat_cnt.sv
// ============================================================================
// sat_cnt : saturating up-counter with synchronous clear; clear+inc loads 1
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] c_max = '1;
    localparam logic [W-1:0] c_one = W'(1);

    logic [W-1:0] r_q;

    // An increment coinciding with a clear counts as the first event after it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= inc ? c_one : '0;
        end else if (inc && (r_q != c_max)) begin
            r_q <= r_q + c_one;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/counter_checker.sv
// ============================================================================
// counter_checker : locks onto an incrementing counter stream and flags breaks
// Optional: define CHK_STATS_EN to add the wrap_cnt statistics output.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_checker
    import counter_chk_pkg::*;
#(
    parameter int WIDTH    = c_def_width,
    parameter int LOCK_CNT = c_def_lock_cnt,
    parameter int ERR_W    = c_def_err_w
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cin,
    input  logic             en,
    input  logic             err_clr,
    output logic             locked,
    output logic             err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] exp_val
`ifdef CHK_STATS_EN
    ,
    output logic [15:0]      wrap_cnt
`endif
);

    localparam int                c_mcw  = $clog2(LOCK_CNT + 1);
    localparam logic [c_mcw-1:0]  c_lock = c_mcw'(LOCK_CNT);
    localparam logic [c_mcw-1:0]  c_m1   = c_mcw'(1);
    localparam logic [WIDTH-1:0]  c_one  = WIDTH'(1);

    state_t             r_state, w_state_nx;
    logic [WIDTH-1:0]   r_prev, w_prev_nx;
    logic [c_mcw-1:0]   r_match, w_match_nx;
    logic [WIDTH-1:0]   w_inc_val;
    logic               w_inc_ok;
    logic               w_viol;
    logic               r_err;
    logic               r_sticky;

    assign w_inc_val = r_prev + c_one;
    assign w_inc_ok  = (cin == w_inc_val);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SEEK;
            r_prev  <= '0;
            r_match <= '0;
        end else begin
            r_state <= w_state_nx;
            r_prev  <= w_prev_nx;
            r_match <= w_match_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_prev_nx  = r_prev;
        w_match_nx = r_match;
        w_viol     = 1'b0;
        if (en) begin
            w_prev_nx = cin;
            case (r_state)
                SEEK: begin
                    w_match_nx = '0;
                    w_state_nx = ACQ;
                end
                ACQ: begin
                    if (w_inc_ok) begin
                        w_match_nx = r_match + c_m1;
                        if ((r_match + c_m1) == c_lock) begin
                            w_state_nx = LOCK;
                        end
                    end else begin
                        w_match_nx = '0;
                    end
                end
                LOCK: begin
                    if (!w_inc_ok) begin
                        w_viol     = 1'b1;
                        w_match_nx = '0;
                        w_state_nx = ACQ;
                    end
                end
                default: begin
                    w_match_nx = '0;
                    w_state_nx = SEEK;
                end
            endcase
        end
    end

    // A violation in the same cycle as err_clr keeps the flag set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err    <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            r_err <= w_viol;
            if (w_viol) begin
                r_sticky <= 1'b1;
            end else if (err_clr) begin
                r_sticky <= 1'b0;
            end
        end
    end

    sat_cnt #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_viol),
        .clr   (err_clr),
        .q     (err_cnt)
    );

`ifdef CHK_STATS_EN
    logic w_wrap;
    assign w_wrap = en && (r_state == LOCK) && w_inc_ok && (cin == '0);

    sat_cnt #(
        .W (16)
    ) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_wrap),
        .clr   (1'b0),
        .q     (wrap_cnt)
    );
`endif

    // Nothing has been sampled while in SEEK, so there is no expectation yet
    assign exp_val    = (r_state == SEEK) ? '0 : w_inc_val;
    assign locked     = (r_state == LOCK);
    assign err        = r_err;
    assign err_sticky = r_sticky;

endmodule

`default_nettype wire
